// File: rtl/queue_fifo.sv
// Tick-paced synchronous FIFO. Push/pop requests act only on divided-clock ticks.
// Overflow and underflow are recorded in sticky flags, and a heartbeat LED toggles on every tick.
module queue_fifo #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 33554432
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           datain,
    output logic [WIDTH-1:0]           dataout,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       udf,
    output logic                       led
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TM = TICK_DIV - 1;
    localparam int DV = DEPTH;
    localparam logic [CW-1:0] TMAX  = TM[CW-1:0];
    localparam logic [AW:0]   FULLV = DV[AW:0];

    logic [CW-1:0]    tcnt;
    logic             tick;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign tick  = (tcnt == TMAX);
    assign full  = (count == FULLV);
    assign empty = (count == '0);

    // A push is allowed when the FIFO is full, provided a pop in the same tick frees an entry.
    always_comb begin
        do_pop  = tick && pop && !empty;
        do_push = tick && push && (!full || do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
            led  <= 1'b0;
        end else begin
            tcnt <= tick ? '0 : tcnt + CW'(1);
            if (tick)
                led <= ~led;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= datain;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dataout <= '0;
            valid   <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            valid <= do_pop;
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop) begin
                rptr    <= rptr + AW'(1);
                dataout <= mem[rptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (tick && push && !do_push)
                ovf <= 1'b1;
            if (tick && pop && !do_pop)
                udf <= 1'b1;
        end
    end
endmodule

// File: doc/queue_fifo.md
QUEUE_FIFO -- requirements
Module: queue_fifo

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits.
REQ-002 Parameter DEPTH, default 16: storage entries; SHALL be a power of two, at least 2.
REQ-003 Parameter TICK_DIV, default 33554432: clk cycles per operation tick; TICK_DIV=1 SHALL give a tick every clk.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low; rst=0 resets all state immediately.
REQ-006 push  input  1  write request, sampled only on tick cycles.
REQ-007 pop  input  1  read request, sampled only on tick cycles.
REQ-008 datain  input  WIDTH  write data, sampled with push.
REQ-009 dataout  output  WIDTH  registered read data; holds the last popped word.
REQ-010 valid  output  1  one-clk pulse on the cycle after a successful pop.
REQ-011 full  output  1  high when count==DEPTH.
REQ-012 empty  output  1  high when count==0.
REQ-013 count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 ovf  output  1  sticky: a push was rejected.
REQ-015 udf  output  1  sticky: a pop was rejected.
REQ-016 led  output  1  tick-rate heartbeat, toggled on every tick.

Function
REQ-017 Tick generator: free-running counter 0..TICK_DIV-1. Internal tick SHALL be high for exactly one clk when the counter equals TICK_DIV-1; the counter then wraps to 0.
REQ-018 No push or pop SHALL be acted on in a non-tick cycle; requests are levels, not latched.
REQ-019 Ordering SHALL be first-in-first-out: words SHALL leave in the order written.
REQ-020 Write pointer wptr and read pointer rptr SHALL each be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 Accepted push: mem[wptr]<=datain, wptr<=wptr+1, count<=count+1.
REQ-022 Accepted pop: dataout<=mem[rptr], rptr<=rptr+1, count<=count-1, valid=1 for the next clk.
REQ-023 Push while full, with pop=0: the push SHALL be rejected. Memory, wptr and count SHALL NOT change, and ovf<=1.
REQ-024 Pop while empty, with push=0: the pop SHALL be rejected. dataout, rptr and count SHALL NOT change, valid stays 0, and udf<=1.
REQ-025 Push and pop on the same tick, not empty: both SHALL be accepted and count SHALL stay the same. dataout SHALL take the oldest word, never the word being written. This SHALL also hold when full; ovf SHALL NOT set.
REQ-026 Push and pop on the same tick while empty: the push SHALL be accepted and the pop rejected. count becomes 1 and udf<=1.
REQ-027 full and empty SHALL be decoded from the registered count; they are valid in the same cycle count updates.
REQ-028 ovf and udf SHALL clear only on reset.
REQ-029 Memory contents SHALL NOT be reset. A word SHALL never be read from an entry that has not been written since reset.

Reset
REQ-030 While rst=0: dataout=0, valid=0, count=0, empty=1, full=0, ovf=0, udf=0, led=0, wptr=0, rptr=0, tick counter=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries. No push or pop SHALL take effect on the clk edge at which rst is 0.
REQ-032 After rst rises, the first tick SHALL occur TICK_DIV clks later.

Verification (TICK_DIV=1, WIDTH=4, DEPTH=16)
REQ-033 Push 1,2,3 on three ticks, then pop three times -> dataout 1,2,3 in order, each with a valid pulse; afterwards empty=1, count=0.
REQ-034 Push 16 words 0..15 -> full=1, count=16. A 17th push with datain=9 -> ovf=1, count=16, and the following 16 pops return 0..15.
REQ-035 Pop while empty -> udf=1, valid=0, dataout unchanged. A following push and pop of value 5 -> dataout=5, and udf stays 1.
REQ-036 Fill to 16, then push=pop=1 with datain=7 -> dataout=0, count=16, ovf=0. Drain to check that 7 is the last word out, for wrap-around of both pointers.
REQ-037 Push 3 words, then drive rst=0 between clk edges -> outputs take their reset values immediately without a clk edge. After release, count=0, and a pop sets udf=1.
REQ-038 With TICK_DIV=4, hold push=1 for 8 clks -> exactly 2 words accepted, count=2, and led toggles twice.
